// File: rtl/rx_oversampler.sv
// UART receive front end: 2-flop line synchroniser, 16x oversampled bit timing,
// 2-of-3 mid-bit majority vote and one baud_tick per frame bit.
module rx_oversampler #(
   parameter int unsigned CLK_DIV    = 27,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic rx_i,
   input  logic enable_i,
   input  logic parity_on_i,
   output logic baud_tick,
   output logic data_o,
   output logic busy_o,
   output logic false_start_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = 4;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BITS  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic               par_q, par_d;
   logic               s7_q, s7_d;
   logic               s8_q, s8_d;
   logic               data_q, data_d;
   logic               tick_q, tick_d;
   logic               busy_q, busy_d;
   logic               fs_q, fs_d;
   logic               sync1_q, sync2_q;
   logic               rx_sync;
   logic               os_tick;
   logic               vote;
   logic [IDX_W-1:0]   last_idx;

   assign rx_sync  = sync2_q;
   assign os_tick  = (div_q == DIV_MAX);
   assign vote     = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);
   assign last_idx = par_q ? IDX_W'(10) : IDX_W'(9);

   // Next-state and datapath; divider and phase free-run across the bits of a frame
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      phase_d   = phase_q;
      bit_idx_d = bit_idx_q;
      par_d     = par_q;
      s7_d      = s7_q;
      s8_d      = s8_q;
      data_d    = data_q;
      tick_d    = 1'b0;
      fs_d      = 1'b0;
      case (state_q)
         IDLE: begin
            data_d = rx_sync;
            if (enable_i && !rx_sync) begin
               state_d   = START;
               bit_idx_d = '0;
               par_d     = parity_on_i;
            end
         end
         START, BITS: begin
            if (!enable_i) begin
               state_d = IDLE;
            end else begin
               div_d = os_tick ? '0 : div_q + DIV_W'(1);
               if (os_tick) begin
                  phase_d = phase_q + PH_W'(1);
                  if (phase_q == PH_W'(7)) s7_d = rx_sync;
                  if (phase_q == PH_W'(8)) s8_d = rx_sync;
                  if (phase_q == PH_W'(9)) begin
                     tick_d = 1'b1;
                     data_d = vote;
                     if (state_q == START) begin
                        if (vote) begin
                           fs_d    = 1'b1;
                           state_d = IDLE;
                        end else begin
                           state_d   = BITS;
                           bit_idx_d = IDX_W'(1);
                        end
                     end else if (bit_idx_q == last_idx) begin
                        state_d = IDLE;
                     end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Timing restarts from zero on every frame
      if (state_d == IDLE) begin
         div_d   = '0;
         phase_d = '0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         phase_q   <= '0;
         bit_idx_q <= '0;
         par_q     <= 1'b0;
         s7_q      <= 1'b1;
         s8_q      <= 1'b1;
         data_q    <= 1'b1;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         fs_q      <= 1'b0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         phase_q   <= phase_d;
         bit_idx_q <= bit_idx_d;
         par_q     <= par_d;
         s7_q      <= s7_d;
         s8_q      <= s8_d;
         data_q    <= data_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
         fs_q      <= fs_d;
         sync1_q   <= rx_i;
         sync2_q   <= sync1_q;
      end
   end

   assign baud_tick     = tick_q;
   assign data_o        = data_q;
   assign busy_o        = busy_q;
   assign false_start_o = fs_q;

endmodule

// File: tb/tb_rx_oversampler.sv
// Bench for rx_oversampler: directed frames; expected ticks (cycle, bit, false-start)
// are queued by the stimulus and checked by an independent monitor.
module tb_rx_oversampler;

   localparam int CD      = 2;
   localparam int BIT_CYC = 16 * CD;

   logic clk = 1'b0;
   logic nrst;
   logic rx_i;
   logic enable_i;
   logic parity_on_i;
   logic baud_tick;
   logic data_o;
   logic busy_o;
   logic false_start_o;

   int tests = 0;
   int errs  = 0;
   int cyc   = 0;

   typedef struct {
      int   cyc;
      logic d;
      logic fs;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   rx_oversampler #(.CLK_DIV(CD), .OVERSAMPLE(16)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .rx_i          (rx_i),
      .enable_i      (enable_i),
      .parity_on_i   (parity_on_i),
      .baud_tick     (baud_tick),
      .data_o        (data_o),
      .busy_o        (busy_o),
      .false_start_o (false_start_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input logic d, input logic fs);
      exp_t e;
      e.cyc = c;
      e.d   = d;
      e.fs  = fs;
      sb.push_back(e);
   endtask

   // Monitor: every tick must match the head of the scoreboard
   always @(negedge clk) begin
      if (baud_tick) begin
         if (sb.size() == 0) begin
            tests++;
            errs++;
            $display("FAIL unexpected_tick at cycle %0d: data_o=%b, expected no tick", cyc, data_o);
         end else begin
            mon_e = sb.pop_front();
            chk("tick_cycle", cyc, mon_e.cyc);
            chk("tick_data", int'(data_o), int'(mon_e.d));
            chk("tick_false_start", int'(false_start_o), int'(mon_e.fs));
         end
      end else if (false_start_o) begin
         chk("stray_false_start", int'(false_start_o), 0);
      end
   end

   task automatic idle_gap(input int n);
      rx_i = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; cut_k>=0 drops enable (or pulses nrst) just after tick cut_k-1
   task automatic run_frame(input logic [7:0] b, input bit par_on, input logic pb,
                            input int spike_k, input int cut_k, input bit use_reset);
      logic bits [0:10];
      int   nb;
      int   n;
      nb      = par_on ? 11 : 10;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      bits[9]  = pb;
      bits[10] = 1'b1;
      bits[nb-1] = 1'b1;
      parity_on_i = par_on;
      @(posedge clk);
      #1;
      n = cyc;
      for (int k = 0; k < nb; k++)
         if (cut_k < 0 || k < cut_k) push(n + 3 + (16 * k + 10) * CD, bits[k], 1'b0);
      for (int k = 0; k < nb; k++) begin
         for (int j = 0; j < BIT_CYC; j++) begin
            if (k != 0 || j != 0) begin
               @(posedge clk);
               #1;
            end
            rx_i = (k == spike_k && (j == 17 || j == 18)) ? 1'b0 : bits[k];
            if (k == 1 && j == 0) chk("busy_mid_frame", int'(busy_o), 1);
            if (cut_k > 0 && k == cut_k - 1 && j == 26) begin
               if (use_reset) nrst = 1'b0;
               else enable_i = 1'b0;
            end
            if (cut_k > 0 && k == cut_k - 1 && j == 27) begin
               chk("busy_after_cut", int'(busy_o), 0);
               chk("tick_after_cut", int'(baud_tick), 0);
               chk("fs_after_cut", int'(false_start_o), 0);
               if (use_reset) begin
                  chk("data_after_reset", int'(data_o), 1);
                  nrst = 1'b1;
               end
            end
         end
      end
      if (cut_k < 0) chk("busy_after_frame", int'(busy_o), 0);
      enable_i = 1'b1;
   endtask

   // Low glitch of four oversample periods on an idle line
   task automatic glitch();
      int n;
      @(posedge clk);
      #1;
      n = cyc;
      push(n + 3 + 10 * CD, 1'b1, 1'b1);
      rx_i = 1'b0;
      repeat (4 * CD) @(posedge clk);
      #1;
      rx_i = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("busy_after_glitch", int'(busy_o), 0);
   endtask

   initial begin
      nrst        = 1'b0;
      rx_i        = 1'b1;
      enable_i    = 1'b1;
      parity_on_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_baud_tick", int'(baud_tick), 0);
      chk("reset_data_o", int'(data_o), 1);
      chk("reset_busy_o", int'(busy_o), 0);
      chk("reset_false_start", int'(false_start_o), 0);
      nrst = 1'b1;
      idle_gap(5);

      run_frame(8'h55, 1'b0, 1'b0, -1, -1, 1'b0);
      idle_gap(5);
      run_frame(8'hA3, 1'b1, 1'b0, -1, -1, 1'b0);
      idle_gap(5);
      glitch();
      idle_gap(5);
      run_frame(8'hFF, 1'b0, 1'b0, 3, -1, 1'b0);
      idle_gap(5);
      run_frame(8'h5A, 1'b0, 1'b0, -1, 3, 1'b0);
      idle_gap(5);
      run_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b0);
      idle_gap(5);
      run_frame(8'hF0, 1'b0, 1'b0, -1, 6, 1'b1);
      idle_gap(5);
      run_frame(8'h96, 1'b0, 1'b0, -1, -1, 1'b0);
      idle_gap(20);

      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule

// File: doc/rx_oversampler.md
RX_OVERSAMPLER -- requirements
Module: rx_oversampler

Purpose: upstream stage of the UART receive FSM. Synchronises the raw serial line, runs a 16x oversampled bit clock, majority-votes each bit at mid-bit, and issues one baud_tick per frame bit together with the voted bit.

Interface
REQ-001 Parameter CLK_DIV, default 27, clocks per oversample tick; legal range 1..65535.
REQ-002 Parameter OVERSAMPLE, default 16, fixed at 16; other values are unsupported.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 rx_i  input  1  raw asynchronous serial line; idles high.
REQ-006 enable_i  input  1  receiver enable.
REQ-007 parity_on_i  input  1  1 = frame carries a parity bit (11 bits total), 0 = 10 bits total.
REQ-008 baud_tick  output  1  one-cycle pulse, once per frame bit at mid-bit.
REQ-009 data_o  output  1  registered voted bit, valid while baud_tick=1.
REQ-010 busy_o  output  1  high while the state is START or BITS.
REQ-011 false_start_o  output  1  one-cycle pulse when the start bit votes high.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchroniser (rx_sync) before any use; no other logic samples rx_i.
REQ-013 States SHALL be IDLE, START and BITS, encoded in a 2-bit register.
REQ-014 In IDLE, data_o SHALL follow rx_sync (registered), the divider and phase SHALL be held at 0, and baud_tick SHALL be 0.
REQ-015 IDLE->START SHALL occur when enable_i=1 and rx_sync=0; on that edge, divider=0, phase=0 and bit_idx=0, and parity_on_i is latched for the frame.
REQ-016 Divider SHALL count 0..CLK_DIV-1 and wrap; os_tick is asserted in the cycle where divider==CLK_DIV-1.
REQ-017 Phase (4 bits) SHALL increment on each os_tick and wrap 15->0.
REQ-018 rx_sync SHALL be captured on the os_tick with phase 7, 8 and 9; the 2-of-3 majority of those samples SHALL be loaded into data_o, and baud_tick SHALL be asserted, in the cycle after the phase-9 os_tick.
REQ-019 Timing: if START is entered at edge E, the baud_tick for frame bit k (k=0 is the start bit) SHALL be high in cycle E+(16k+10)*CLK_DIV.
REQ-020 START on the vote: if the vote is 0, go to BITS with bit_idx=1; if the vote is 1, pulse false_start_o with that same baud_tick (data_o=1) and go to IDLE.
REQ-021 BITS: after the tick for the last bit (bit_idx==9 when parity is off, ==10 when on), go to IDLE on the same edge; otherwise increment bit_idx.
REQ-022 Return to IDLE SHALL occur at mid-stop-bit, so a following start edge is accepted immediately.
REQ-023 enable_i=0 in START or BITS SHALL abort to IDLE on the next edge, with no further baud_tick or false_start_o.
REQ-024 baud_tick and false_start_o SHALL never be high for more than one consecutive cycle.
REQ-025 With CLK_DIV=1, os_tick SHALL be high every cycle.
REQ-026 The divider width SHALL be $clog2 of CLK_DIV, minimum 1 bit; there is no overflow path.

Reset
REQ-027 nrst=0 at an edge SHALL force: state=IDLE, divider=0, phase=0, bit_idx=0, both synchroniser flops=1, data_o=1, baud_tick=0, busy_o=0, false_start_o=0.
REQ-028 Reset mid-frame SHALL discard the frame; no tick is emitted for it after nrst returns to 1.

Verification
REQ-029 CLK_DIV=2, parity off, frame 0x55 LSB-first: exactly 10 baud_ticks at E+20, E+52, ... E+308; data_o = 0,1,0,1,0,1,0,1,0,1; busy_o drops after the last tick.
REQ-030 CLK_DIV=2, parity on: exactly 11 ticks; the 11th data_o equals the driven stop bit (1).
REQ-031 A 4-oversample-period low glitch on an idle line: one baud_tick with data_o=1, a false_start_o pulse in the same cycle, and a return to IDLE.
REQ-032 A single-os_tick low spike at phase 8 inside a high data bit: the majority vote gives data_o=1 for that bit.
REQ-033 enable_i dropped after the 3rd tick: no further ticks and busy_o=0 on the next cycle; a later clean frame is received normally.
REQ-034 nrst pulsed low at bit 5: all outputs return to their reset values; the next frame starts cleanly with its first tick at E+20.
